// File: rtl/fetch_ctrl.sv
// Fetch/PC-select controller: RUN/STALL/FLUSH FSM with Mealy PC-select outputs and a sticky stall watchdog.
// Optional FETCH_CTRL_PERF_EN adds saturating br_cnt/stall_cnt performance counters.
module fetch_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int STALL_MAX    = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mem_busy,
  input  logic       br_req0,
  input  logic       br_req1,
  input  logic [7:0] br_imm0,
  input  logic [7:0] br_imm1,
  input  logic       dep_hazard,
  output logic       pc_stall,
  output logic       pc_rollback,
  output logic       pc_branch1,
  output logic       pc_branch2,
  output logic [7:0] pc_imm,
  output logic       flush,
  output logic       busy,
  output logic       wdog_err
`ifdef FETCH_CTRL_PERF_EN
  ,
  output logic [7:0] br_cnt,
  output logic [7:0] stall_cnt
`endif
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2,
    BAD   = 2'd3
  } state_t;

  localparam logic [7:0] SMAX = 8'(STALL_MAX);
  localparam logic [3:0] FCYC = 4'(FLUSH_CYCLES);

  state_t     r_state, w_state_nxt;
  logic [7:0] r_stall_cnt, w_stall_cnt_nxt, w_stall_inc;
  logic [3:0] r_flush_cnt, w_flush_cnt_nxt;
  logic       r_wdog, w_wdog_set;
  logic       w_stall, w_rollback, w_branch1, w_branch2, w_flush;
  logic [7:0] w_imm;

  assign w_stall_inc = (r_stall_cnt == 8'hFF) ? r_stall_cnt : r_stall_cnt + 8'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= RUN;
      r_stall_cnt <= 8'd0;
      r_flush_cnt <= 4'd0;
      r_wdog      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_stall_cnt <= w_stall_cnt_nxt;
      r_flush_cnt <= w_flush_cnt_nxt;
      if (w_wdog_set) r_wdog <= 1'b1;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_stall_cnt_nxt = r_stall_cnt;
    w_flush_cnt_nxt = r_flush_cnt;
    w_wdog_set      = 1'b0;
    w_stall         = 1'b0;
    w_rollback      = 1'b0;
    w_branch1       = 1'b0;
    w_branch2       = 1'b0;
    w_flush         = 1'b0;
    w_imm           = 8'd0;
    case (r_state)
      RUN: begin
        if (mem_busy) begin
          w_stall = 1'b1;
          // A watchdog limit of 1 trips on the very first stall cycle.
          if (SMAX == 8'd1) begin
            w_wdog_set      = 1'b1;
            w_stall_cnt_nxt = 8'd0;
          end else begin
            w_state_nxt     = STALL;
            w_stall_cnt_nxt = 8'd1;
          end
        end else if (br_req0) begin
          w_branch1       = 1'b1;
          w_imm           = br_imm0;
          w_state_nxt     = FLUSH;
          w_flush_cnt_nxt = FCYC;
        end else if (br_req1) begin
          w_branch2       = 1'b1;
          w_imm           = br_imm1;
          w_state_nxt     = FLUSH;
          w_flush_cnt_nxt = FCYC;
        end else if (dep_hazard) begin
          w_rollback = 1'b1;
        end
      end
      STALL: begin
        w_stall = 1'b1;
        if (mem_busy) begin
          if (w_stall_inc == SMAX) begin
            w_wdog_set      = 1'b1;
            w_state_nxt     = RUN;
            w_stall_cnt_nxt = 8'd0;
          end else begin
            w_stall_cnt_nxt = w_stall_inc;
          end
        end else begin
          w_state_nxt     = RUN;
          w_stall_cnt_nxt = 8'd0;
        end
      end
      FLUSH: begin
        w_flush = 1'b1;
        if (mem_busy) begin
          w_stall = 1'b1;
        end else begin
          w_flush_cnt_nxt = r_flush_cnt - 4'd1;
          if (r_flush_cnt <= 4'd1) begin
            w_state_nxt     = RUN;
            w_flush_cnt_nxt = 4'd0;
          end
        end
      end
      default: begin
        w_state_nxt     = RUN;
        w_stall_cnt_nxt = 8'd0;
        w_flush_cnt_nxt = 4'd0;
      end
    endcase
  end

  // Outputs are forced low for the whole reset window, not just after the edge.
  assign pc_stall    = w_stall    & ~reset;
  assign pc_rollback = w_rollback & ~reset;
  assign pc_branch1  = w_branch1  & ~reset;
  assign pc_branch2  = w_branch2  & ~reset;
  assign flush       = w_flush    & ~reset;
  assign pc_imm      = reset ? 8'd0 : w_imm;
  assign busy        = ((r_state == STALL) || (r_state == FLUSH)) & ~reset;
  assign wdog_err    = r_wdog & ~reset;

`ifdef FETCH_CTRL_PERF_EN
  logic [7:0] r_br_cnt, r_stall_pc_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_br_cnt       <= 8'd0;
      r_stall_pc_cnt <= 8'd0;
    end else begin
      if ((pc_branch1 || pc_branch2) && r_br_cnt != 8'hFF) r_br_cnt <= r_br_cnt + 8'd1;
      if (pc_stall && r_stall_pc_cnt != 8'hFF) r_stall_pc_cnt <= r_stall_pc_cnt + 8'd1;
    end
  end

  assign br_cnt    = r_br_cnt;
  assign stall_cnt = r_stall_pc_cnt;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl (FLUSH_CYCLES=2, STALL_MAX=4); perf counters checked when FETCH_CTRL_PERF_EN is defined.
module tb_fetch_ctrl;
  logic       clk = 1'b0;
  logic       reset;
  logic       mem_busy, br_req0, br_req1, dep_hazard;
  logic [7:0] br_imm0, br_imm1;
  logic       pc_stall, pc_rollback, pc_branch1, pc_branch2, flush, busy, wdog_err;
  logic [7:0] pc_imm;
`ifdef FETCH_CTRL_PERF_EN
  logic [7:0] br_cnt, stall_cnt;
`endif

  int n_chk = 0;
  int n_err = 0;

  // Flag order: {pc_stall, pc_rollback, pc_branch1, pc_branch2, flush, busy, wdog_err}
  localparam logic [6:0] S  = 7'b1000000;
  localparam logic [6:0] R  = 7'b0100000;
  localparam logic [6:0] B1 = 7'b0010000;
  localparam logic [6:0] B2 = 7'b0001000;
  localparam logic [6:0] F  = 7'b0000100;
  localparam logic [6:0] BU = 7'b0000010;
  localparam logic [6:0] W  = 7'b0000001;
  localparam logic [6:0] Z  = 7'b0000000;

  fetch_ctrl #(.FLUSH_CYCLES(2), .STALL_MAX(4)) dut (
    .clk(clk), .reset(reset), .mem_busy(mem_busy), .br_req0(br_req0), .br_req1(br_req1),
    .br_imm0(br_imm0), .br_imm1(br_imm1), .dep_hazard(dep_hazard),
    .pc_stall(pc_stall), .pc_rollback(pc_rollback), .pc_branch1(pc_branch1),
    .pc_branch2(pc_branch2), .pc_imm(pc_imm), .flush(flush), .busy(busy), .wdog_err(wdog_err)
`ifdef FETCH_CTRL_PERF_EN
    , .br_cnt(br_cnt), .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, check Mealy outputs mid-cycle, advance past the edge.
  task automatic step(input string tag, input logic mb, input logic b0, input logic b1,
                      input logic [7:0] i0, input logic [7:0] i1, input logic dh,
                      input logic [6:0] ef, input logic [7:0] ei);
    mem_busy = mb; br_req0 = b0; br_req1 = b1; br_imm0 = i0; br_imm1 = i1; dep_hazard = dh;
    @(negedge clk);
    chk({tag, ".flags"}, {25'd0, pc_stall, pc_rollback, pc_branch1, pc_branch2, flush, busy, wdog_err}, {25'd0, ef});
    chk({tag, ".imm"}, {24'd0, pc_imm}, {24'd0, ei});
    @(posedge clk); #1;
  endtask

  task automatic idle(input string tag, input logic [6:0] ef);
    step(tag, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, ef, 8'h00);
  endtask

  // Reset with busy/branch inputs active: every output must read 0.
  task automatic do_reset(input string tag);
    reset = 1'b1;
    step(tag, 1'b1, 1'b1, 1'b1, 8'h11, 8'h22, 1'b1, Z, 8'h00);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; mem_busy = 0; br_req0 = 0; br_req1 = 0; br_imm0 = 0; br_imm1 = 0; dep_hazard = 0;
    @(posedge clk); #1;
    do_reset("rst");
    idle("run_idle", Z);

    // Slot-0 branch wins over slot-1; two flush cycles ignore branch/hazard.
    step("br0", 1'b0, 1'b1, 1'b1, 8'h03, 8'h05, 1'b0, B1, 8'h03);
    step("fl0a", 1'b0, 1'b1, 1'b0, 8'h09, 8'h00, 1'b1, F | BU, 8'h00);
    idle("fl0b", F | BU);
    idle("br0_done", Z);

    // Slot-1 branch over hazard, then plain hazard rollback.
    step("br1", 1'b0, 1'b0, 1'b1, 8'h00, 8'h05, 1'b1, B2, 8'h05);
    idle("fl1a", F | BU);
    idle("fl1b", F | BU);
    step("haz", 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, R, 8'h00);
    idle("haz_run", Z);

    // Three busy cycles: four stall cycles, branch ignored in STALL.
    step("st0", 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, S, 8'h00);
    step("st1", 1'b1, 1'b1, 1'b0, 8'h04, 8'h00, 1'b0, S | BU, 8'h00);
    step("st2", 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, S | BU, 8'h00);
    step("st3", 1'b0, 1'b1, 1'b0, 8'h04, 8'h00, 1'b1, S | BU, 8'h00);
    idle("st_done", Z);

    // Memory busy during flush: flush counter holds.
    step("brf", 1'b0, 1'b1, 1'b0, 8'h07, 8'h00, 1'b0, B1, 8'h07);
    step("flm1", 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, S | F | BU, 8'h00);
    step("flm2", 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, S | F | BU, 8'h00);
    idle("flm3", F | BU);
    idle("flm4", F | BU);
    idle("flm_done", Z);

    // Reset one cycle into flush abandons it.
    step("brr", 1'b0, 1'b1, 1'b0, 8'h02, 8'h00, 1'b0, B1, 8'h02);
    idle("flr", F | BU);
    do_reset("rst_fl");
    idle("post_rst_a", Z);
    idle("post_rst_b", Z);

    // Reset mid-stall leaves no residual stall.
    step("str0", 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, S, 8'h00);
    do_reset("rst_st");
    idle("post_rst_st", Z);

    // Watchdog at STALL_MAX=4: trips after the 4th stall cycle, forced to RUN, sticky.
    step("wd0", 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, S, 8'h00);
    step("wd1", 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, S | BU, 8'h00);
    step("wd2", 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, S | BU, 8'h00);
    step("wd3", 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, S | BU, 8'h00);
    step("wd4", 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, S | W, 8'h00);
    step("wd5", 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, S | BU | W, 8'h00);
    idle("wd6", W);
    step("wd_br", 1'b0, 1'b0, 1'b1, 8'h00, 8'h0A, 1'b0, B2 | W, 8'h0A);
    idle("wd_fl", F | BU | W);
    do_reset("rst_wd");
    idle("wd_clr", Z);

`ifdef FETCH_CTRL_PERF_EN
    do_reset("rst_perf");
    chk("br_cnt_rst", {24'd0, br_cnt}, 32'd0);
    chk("stall_cnt_rst", {24'd0, stall_cnt}, 32'd0);
    step("pst0", 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, S, 8'h00);
    step("pst1", 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, S | BU, 8'h00);
    step("pst2", 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, S | BU, 8'h00);
    step("pst3", 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, S | BU, 8'h00);
    chk("stall_cnt4", {24'd0, stall_cnt}, 32'd4);
    chk("br_cnt0", {24'd0, br_cnt}, 32'd0);
    for (int i = 0; i < 300; i++) begin
      br_req0 = 1'b1;
      @(posedge clk); #1;
      br_req0 = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
    end
    chk("br_cnt_sat", {24'd0, br_cnt}, 32'd255);
    chk("stall_cnt_keep", {24'd0, stall_cnt}, 32'd4);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter: FLUSH_CYCLES, 2, bubble cycles after a taken branch; legal range 1..15.
REQ-002 Parameter: STALL_MAX, 255, memory-wait cycles before watchdog error; legal range 1..255.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 reset  in  1  reset, asynchronous, active-high.
REQ-005 mem_busy  in  1  instruction memory not ready; PC must hold.
REQ-006 br_req0  in  1  slot-0 branch resolved taken this cycle.
REQ-007 br_req1  in  1  slot-1 branch resolved taken this cycle.
REQ-008 br_imm0  in  8  slot-0 branch offset, in words.
REQ-009 br_imm1  in  8  slot-1 branch offset, in words.
REQ-010 dep_hazard  in  1  slot 1 depends on slot 0; issue slot 0 only.
REQ-011 pc_stall  out  1  hold the PC.
REQ-012 pc_rollback  out  1  next PC = PC+4.
REQ-013 pc_branch1  out  1  next PC = PC+imm*4.
REQ-014 pc_branch2  out  1  next PC = PC+imm*4+4.
REQ-015 pc_imm  out  8  offset for the PC; 0 when no branch is asserted.
REQ-016 flush  out  1  kill the fetched instruction pair.
REQ-017 busy  out  1  controller is not in RUN.
REQ-018 wdog_err  out  1  sticky stall-watchdog error.

Function
REQ-019 The FSM SHALL have states RUN=2'd0, STALL=2'd1 and FLUSH=2'd2; 2'd3 SHALL recover to RUN on the next edge with all outputs 0.
REQ-020 At most one of pc_stall, pc_rollback, pc_branch1 and pc_branch2 SHALL be 1 in any cycle; all 0 means next PC = PC+8.
REQ-021 Outputs SHALL be Mealy (combinational from state and inputs), so control reaches the PC in the same cycle.
REQ-022 RUN input priority SHALL be: mem_busy > br_req0 > br_req1 > dep_hazard > none.
REQ-023 RUN with mem_busy=1: pc_stall=1; next state STALL; stall counter loads 1.
REQ-024 RUN with br_req0=1: pc_branch1=1, pc_imm=br_imm0; next state FLUSH; flush counter loads FLUSH_CYCLES.
REQ-025 RUN with br_req0=0 and br_req1=1: pc_branch2=1, pc_imm=br_imm1; next state FLUSH; flush counter loads FLUSH_CYCLES.
REQ-026 RUN with dep_hazard only: pc_rollback=1; remain in RUN.
REQ-027 STALL: pc_stall=1 unconditionally, and branch and hazard inputs SHALL be ignored.
REQ-028 STALL exit: mem_busy sampled 0 SHALL give RUN on the next edge, so there is exactly one extra stall cycle.
REQ-029 STALL with mem_busy=1: stall counter increments (8-bit, saturating).
REQ-030 Watchdog: when the stall counter reaches STALL_MAX, wdog_err SHALL set, state SHALL force to RUN, and the counter SHALL clear.
REQ-031 wdog_err SHALL stay set until reset.
REQ-032 FLUSH: flush=1; branch and hazard inputs SHALL be ignored.
REQ-033 FLUSH with mem_busy=1: pc_stall=1 and the flush counter holds.
REQ-034 FLUSH with mem_busy=0: pc_stall=0 (PC+8) and the flush counter decrements.
REQ-035 FLUSH: on the decrement from 1 to 0, next state SHALL be RUN.
REQ-036 busy SHALL be 1 exactly when the state is not RUN.

Reset
REQ-037 reset SHALL force state RUN, zero all counters, and clear wdog_err.
REQ-038 While reset=1, all outputs SHALL be 0.
REQ-039 Reset asserted mid-STALL or mid-FLUSH SHALL abandon the operation with no residual flush or stall after release.

Configuration
REQ-040 FETCH_CTRL_PERF_EN defined: add outputs br_cnt[7:0] and stall_cnt[7:0], both cleared by reset.
REQ-041 br_cnt SHALL count cycles with pc_branch1 or pc_branch2 asserted and saturate at 255.
REQ-042 stall_cnt SHALL count cycles with pc_stall=1 and saturate at 255.
REQ-043 FETCH_CTRL_PERF_EN undefined: these ports and their logic SHALL be absent, and all other behaviour is identical.

Verification
REQ-044 RUN, br_req0=1, br_req1=1, br_imm0=8'h03, br_imm1=8'h05 for one cycle -> pc_branch1=1, pc_imm=8'h03, pc_branch2=0; then flush=1 for 2 cycles; then RUN.
REQ-045 RUN, br_req1=1 and dep_hazard=1 -> pc_branch2=1 and pc_rollback=0; the next cycle with only dep_hazard=1 -> pc_rollback=1 and state stays RUN.
REQ-046 mem_busy=1 for 3 cycles from RUN -> pc_stall=1 for 4 cycles and busy=1 for 3 cycles, with br_req0 pulses during STALL ignored.
REQ-047 STALL_MAX=4, mem_busy held 1 -> wdog_err=1 after the 4th stall cycle, state RUN, and wdog_err stays 1 until reset.
REQ-048 Branch, then mem_busy=1 for 2 cycles in FLUSH -> flush=1 for 4 cycles total and pc_stall=1 for 2 of them.
REQ-049 Branch, then reset asserted 1 cycle into FLUSH -> all outputs 0, and after release no flush with state RUN.
REQ-050 With FETCH_CTRL_PERF_EN defined, 300 taken branches -> br_cnt=255.
